// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > hold > load.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= IFID_BUBBLE;
    end else if (flush) begin
      q_q <= IFID_BUBBLE;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect/stall/halt control, range checks, IF/ID capture.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic        oob_err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            oob_q, oob_d;
  logic            ifid_load, ifid_flush;
  ifid_t           ifid_d, ifid_q;
  logic            pc_oob;

  assign pc_oob = (pc_q >> 2) >= XLEN'(IMEM_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      oob_q      <= oob_d;
    end
  end

  // Priority: redirect > stall > per-state behaviour.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    oob_d      = oob_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_d     = '{instr: instr_in, pc: pc_q, pc_plus4: pc_q + XLEN'(4), valid: 1'b1};
    if (redirect) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      ifid_flush = 1'b1;
      state_d    = RUN;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (!stall) begin
      case (state_q)
        RUN: begin
          if (pc_oob) begin
            oob_d      = 1'b1;
            ifid_flush = 1'b1;
            state_d    = HALT;
          end else if (instr_in == HALT_WORD) begin
            ifid_load = 1'b1;
            state_d   = HALT;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + XLEN'(4);
          end
        end
        HALT:    ifid_flush = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign pc            = pc_q;
  assign halted        = (state_q == HALT);
  assign misalign_err  = misalign_q;
  assign oob_err       = oob_q;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus random stall/redirect/reset traffic.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] HW    = 32'hFFFF_FFFF;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc, instr_in, ifid_instr, ifid_pc, ifid_pc_plus4;
  logic        ifid_valid, halted, misalign_err, oob_err;

  logic [31:0] mem [64];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        v;
    logic        h;
    logic        me;
    logic        oe;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done = 1'b0;

  fetch_stage #(.RESET_PC(RPC), .IMEM_DEPTH(DEPTH), .HALT_WORD(HW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .instr_in(instr_in), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid), .halted(halted),
    .misalign_err(misalign_err), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  assign instr_in = mem[pc[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural reference: what one clock edge should do to the fetch unit.
  task automatic model_step(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
    logic [31:0] w;
    if (r) begin
      m = '{pc: RPC, instr: 0, ipc: 0, ipc4: 0, v: 0, h: 0, me: 0, oe: 0};
    end else if (rd) begin
      m.pc = (tgt / 4) * 4;
      m.instr = 0; m.v = 0;
      if (tgt % 4 != 0) m.me = 1;
      m.h = 0;
    end else if (s) begin
      // nothing changes
    end else if (m.h) begin
      m.instr = 0; m.v = 0;
    end else if (m.pc / 4 >= DEPTH) begin
      m.oe = 1; m.instr = 0; m.v = 0; m.h = 1;
    end else begin
      w = mem[(m.pc / 4) % 64];
      m.instr = w; m.ipc = m.pc; m.ipc4 = m.pc + 4; m.v = 1;
      if (w == HW) m.h = 1;
      else m.pc = m.pc + 4;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = tgt;
    model_step(r, s, rd, tgt);
    q.push_back(m);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a new fetch state after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("ifid_valid", 32'(ifid_valid), 32'(e.v));
      chk("ifid_instr", ifid_instr, e.instr);
      if (e.v) begin
        chk("ifid_pc", ifid_pc, e.ipc);
        chk("ifid_pc_plus4", ifid_pc_plus4, e.ipc4);
      end
      chk("halted", 32'(halted), 32'(e.h));
      chk("misalign_err", 32'(misalign_err), 32'(e.me));
      chk("oob_err", 32'(oob_err), 32'(e.oe));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == HW) w = 32'h1234_5678;
      mem[i] = w;
    end
    m = '{pc: RPC, instr: 0, ipc: 0, ipc4: 0, v: 0, h: 0, me: 0, oe: 0};

    // free run from reset
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    run(4);
    // stall at pc 8
    cyc(1, 0, 0, 0); run(2);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    run(1);
    // misaligned redirect together with stall at pc 12
    cyc(1, 0, 0, 0); run(3);
    cyc(0, 1, 1, 32'h0000_0006);
    run(2);
    // halt word at word 5, bubbles, stall in HALT, redirect back to 0
    mem[5] = HW;
    cyc(1, 0, 0, 0); run(6);
    run(2); cyc(0, 1, 0, 0); run(1);
    cyc(0, 0, 1, 32'h0);
    run(2);
    mem[5] = 32'h0000_0013;
    // run off the end of memory
    cyc(1, 0, 0, 0); run(DEPTH + 3);
    // reset wins over a pending redirect
    cyc(0, 0, 1, 32'h0000_0040);
    cyc(1, 0, 1, 32'h0000_0040);
    run(1);

    // random traffic with a few halt words planted
    mem[3] = HW; mem[6] = HW;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit r, s, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 25);
      rd = ($urandom_range(0, 99) < 10);
      t  = 32'($urandom_range(0, DEPTH * 4 + 8));
      cyc(r, s, rd, t);
    end

    cyc(0, 1, 0, 0);
    @(posedge clk); #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter and drives it to the memory's byte-address input.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles sequential increment, branch/jump redirect, stall, halt detection and address-range checking.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 32, instruction memory depth in 32-bit words; valid byte addresses are 0 to IMEM_DEPTH*4-4.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode; hold PC and IF/ID.
- redirect  in  1  taken branch or jump resolved downstream.
- redirect_pc  in  32  byte target for redirect.
- pc  out  32  current fetch address, to instruction memory.
- instr_in  in  32  instruction word returned combinationally for pc.
- ifid_instr  out  32  registered instruction.
- ifid_pc  out  32  registered PC of ifid_instr.
- ifid_pc_plus4  out  32  ifid_pc + 4.
- ifid_valid  out  1  ifid_instr is a real instruction (0 = bubble).
- halted  out  1  fetch is in HALT state.
- misalign_err  out  1  sticky; a redirect target had bits [1:0] != 0.
- oob_err  out  1  sticky; pc left the memory range.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - pc = RESET_PC.
  - ifid_instr = NOP (32'h0).
  - ifid_pc = 0, ifid_pc_plus4 = 0.
  - ifid_valid = 0, halted = 0.
  - misalign_err = 0, oob_err = 0.
  - State = RUN.
- rst overrides everything. Reset asserted mid-redirect or mid-stall discards that request.
- Latency: instr_in for address pc appears on ifid_* at the next edge, i.e. 1 cycle.
- States: RUN and HALT. Priority each cycle: rst > redirect > stall > normal.
- RUN, redirect=1:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID loads NOP with ifid_valid = 0 (flush of the wrong-path fetch).
  - misalign_err set if redirect_pc[1:0] != 0.
  - Redirect wins over a simultaneous stall.
- RUN, stall=1, no redirect: pc and all ifid_* hold their values.
- RUN, normal:
  - ifid_instr <= instr_in, ifid_pc <= pc, ifid_pc_plus4 <= pc + 4, ifid_valid <= 1.
  - pc <= pc + 4; 32-bit arithmetic, wraps modulo 2^32.
- RUN -> HALT on a normal-capture cycle when either:
  - instr_in == HALT_WORD: the halt word itself is latched with ifid_valid = 1; pc holds.
  - (pc >> 2) >= IMEM_DEPTH: set oob_err; ifid_valid <= 0; pc holds.
- A stalled cycle never triggers a transition. The check is re-evaluated when the stall releases.
- HALT:
  - halted = 1; pc holds.
  - While stall = 1, IF/ID holds. While stall = 0, IF/ID loads NOP with ifid_valid = 0.
- HALT -> RUN only on redirect, which covers a halt fetched on a wrong path. Redirect handling is identical to RUN.
- halted is a registered output equal to (state == HALT).
- The error flags are sticky until rst.

Decomposition:
- Package cpu_pkg:
  - XLEN = 32, NOP_INSTR = 32'h0, default HALT_WORD.
  - Typedef fetch_state_t enum {RUN, HALT}.
  - Typedef ifid_t struct {instr, pc, pc_plus4, valid}.
- Sub-module ifid_reg:
  - The IF/ID pipeline register.
  - Inputs: load, flush, d (ifid_t). Output: q.
  - Priority inside: rst > flush > hold (load = 0) > load.
- fetch_stage contains the PC register, next-PC logic, state machine and error flags, and instantiates ifid_reg.

Test Plan:
- Reset then 4 free-running cycles with memory words 0..3 = A, B, C, D.
  - ifid_instr sequence A, B, C, D; ifid_pc sequence 0, 4, 8, 12; ifid_valid = 1 from the first edge after rst falls; pc = 16.
- At pc = 8, assert stall for 2 cycles.
  - pc stays 8 and ifid holds word 1 / pc 4 for both cycles.
  - On release, ifid = word 2 / pc 8.
- At pc = 12, assert redirect = 1, redirect_pc = 32'h0000_0006, together with stall = 1.
  - Next cycle: pc = 4, ifid_valid = 0, ifid_instr = 0, misalign_err = 1.
  - Following cycle: ifid = word 1 / pc 4.
- Place HALT_WORD at word 5.
  - ifid_instr = FFFF_FFFF with valid = 1, halted = 1, pc stays 20.
  - Subsequent cycles: ifid_valid = 0.
  - Then redirect to 0: halted = 0 and fetch resumes at word 0.
- Run off the end with IMEM_DEPTH = 4 and no halt word.
  - After pc = 12 is captured, pc = 16 triggers oob_err = 1 and halted = 1; ifid_valid = 0; pc holds 16.
- Assert rst while a redirect to 0x40 is pending.
  - pc = RESET_PC and all outputs at reset values; the redirect is ignored.
